// File: rtl/pwm_dac_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_dac_mc_if
// Description : Bus-bridge side of the multi-channel PWM DAC. Carries frame
//               pushes, FIFO control and the FIFO/flag status.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_dac_mc_if #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 1024
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                           we;
  logic [CHANNELS*SAMPLE_W-1:0]   frame_i;
  logic                           flush;
  logic                           clr_flags;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [LVL_W-1:0]               fifo_level;
  logic                           underrun;
  logic                           overflow;

  // Bridge side: drives pushes/control, reads status
  modport master (
    output we, frame_i, flush, clr_flags,
    input  fifo_full, fifo_empty, fifo_level, underrun, overflow
  );

  // DAC side: accepts pushes/control, reports status
  modport slave (
    input  we, frame_i, flush, clr_flags,
    output fifo_full, fifo_empty, fifo_level, underrun, overflow
  );
endinterface
`default_nettype wire

// File: rtl/pwm_dac_mc.sv
`default_nettype none
// ============================================================================
// Module      : pwm_dac_mc
// Description : Multi-channel first-order delta-sigma / PWM audio DAC with a
//               first-word-fall-through frame FIFO, programmable sample-rate
//               divider, signed/unsigned sample format, underrun policy and
//               sticky underrun/overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_dac_mc #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 1024,
  parameter int DIV_W    = 18
) (
  input  wire logic              clk,
  input  wire logic              resetn,
  input  wire logic              enable,
  input  wire logic              signed_mode,
  input  wire logic              hold_on_underrun,
  input  wire logic [DIV_W-1:0]  rate_div,
  pwm_dac_mc_if.slave            bus,
  output logic [CHANNELS-1:0]    pwm_o
);

  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int FRAME_W = CHANNELS * SAMPLE_W;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
  // Midscale value; also the MSB mask used to turn two's complement into
  // offset-binary.
  localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic               underrun_q, underrun_d;
  logic               overflow_q, overflow_d;

  logic               fifo_empty_w;
  logic               fifo_full_w;
  logic               tick;
  logic               pop;
  logic               push;
  logic               underrun_set;
  logic               overflow_set;
  logic [FRAME_W-1:0] head;

  // Head of the FIFO is always visible (first-word-fall-through)
  assign head = mem_q[rd_ptr_q];

  // Divider, FIFO bookkeeping and flag next-state logic
  always_comb begin
    fifo_empty_w = (level_q == '0);
    fifo_full_w  = (level_q == DEPTH_LVL);

    // >= so that lowering rate_div mid-period ticks at once instead of wrapping
    tick = enable && (cnt_q >= rate_div);

    // flush wins over both pop and push
    pop  = tick && !fifo_empty_w && !bus.flush;
    // A pop in the same cycle frees the slot a full FIFO needs
    push = bus.we && !bus.flush && (!fifo_full_w || pop);

    overflow_set = bus.we && !bus.flush && fifo_full_w && !pop;
    // A frame pushed into an empty FIFO on a tick is not yet visible: underrun
    underrun_set = tick && fifo_empty_w;

    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (bus.flush) begin
      level_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      level_d  = level_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (push && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    // A same-cycle set beats clr_flags
    underrun_d = underrun_set || (underrun_q && !bus.clr_flags);
    overflow_d = overflow_set || (overflow_q && !bus.clr_flags);
  end

  // Frame storage; no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.frame_i;
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.fifo_full  = fifo_full_w;
  assign bus.fifo_empty = fifo_empty_w;
  assign bus.fifo_level = level_q;
  assign bus.underrun   = underrun_q;
  assign bus.overflow   = overflow_q;

  // --------------------------------------------------------------------------
  // Per-channel sample register, accumulator and output bit
  // --------------------------------------------------------------------------
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [SAMPLE_W:0]   acc_q, acc_d;
    logic                pwm_q, pwm_d;

    // Sample load, first-order accumulation and output bit selection
    always_comb begin
      sample_d = sample_q;
      if (!enable) begin
        sample_d = '0;
      end else if (pop) begin
        sample_d = head[n*SAMPLE_W +: SAMPLE_W] ^ (signed_mode ? MIDSCALE : '0);
      end else if (underrun_set && !bus.flush && !hold_on_underrun) begin
        sample_d = MIDSCALE;
      end

      // Carry out of the low SAMPLE_W bits is the delta-sigma bitstream
      if (enable) begin
        acc_d = {1'b0, acc_q[SAMPLE_W-1:0]} + {1'b0, sample_q};
      end else begin
        acc_d = '0;
      end

      pwm_d = enable && acc_q[SAMPLE_W];
    end

    // Channel registers with asynchronous reset
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sample_q <= '0;
        acc_q    <= '0;
        pwm_q    <= 1'b0;
      end else begin
        sample_q <= sample_d;
        acc_q    <= acc_d;
        pwm_q    <= pwm_d;
      end
    end

    assign pwm_o[n] = pwm_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_dac_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_dac_mc
// Description : Directed self-checking bench for pwm_dac_mc (2 ch, 8-bit,
//               4-deep FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_dac_mc;
  localparam int CH    = 2;
  localparam int SW    = 8;
  localparam int DEPTH = 4;
  localparam int DIV_W = 18;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             enable = 1'b0;
  logic             signed_mode = 1'b0;
  logic             hold_on_underrun = 1'b1;
  logic [DIV_W-1:0] rate_div = '0;
  logic [CH-1:0]    pwm_o;

  int checks   = 0;
  int failures = 0;

  pwm_dac_mc_if #(.CHANNELS(CH), .SAMPLE_W(SW), .DEPTH(DEPTH)) bus ();

  pwm_dac_mc #(.CHANNELS(CH), .SAMPLE_W(SW), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .enable           (enable),
    .signed_mode      (signed_mode),
    .hold_on_underrun (hold_on_underrun),
    .rate_div         (rate_div),
    .bus              (bus.slave),
    .pwm_o            (pwm_o)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [15:0] f);
    bus.frame_i = f;
    bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_flags = 1'b1;
    @(negedge clk);
    bus.clr_flags = 1'b0;
  endtask

  task automatic count_highs(output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      c0 += int'(pwm_o[0]);
      c1 += int'(pwm_o[1]);
    end
  endtask

  // Load one frame from an otherwise empty FIFO and measure both duties
  task automatic run_frame(input string name, input logic [15:0] frame,
                           input logic [DIV_W-1:0] rate, input int e0, input int e1);
    int c0, c1;
    bit seen;
    enable = 1'b0;
    @(negedge clk);
    pulse_flush();
    push(frame);
    rate_div = rate;
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < int'(rate) + 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.fifo_empty) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL %s_pop: fifo_empty got 0 required 1 within bound", name);
    end
    repeat (3) @(negedge clk);
    count_highs(c0, c1);
    checks++;
    if (c0 !== e0) begin
      failures++;
      $display("FAIL %s_ch0: highs got %0d required %0d", name, c0, e0);
    end
    checks++;
    if (c1 !== e1) begin
      failures++;
      $display("FAIL %s_ch1: highs got %0d required %0d", name, c1, e1);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (pwm_o !== 2'b00) begin failures++; $display("FAIL reset_pwm: got %b required 00", pwm_o); end
    checks++;
    if (bus.fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d required 0", bus.fifo_level); end
    checks++;
    if ({bus.fifo_empty, bus.fifo_full} !== 2'b10) begin
      failures++; $display("FAIL reset_empty_full: got %b required 10", {bus.fifo_empty, bus.fifo_full});
    end
    checks++;
    if ({bus.underrun, bus.overflow} !== 2'b00) begin
      failures++; $display("FAIL reset_flags: got %b required 00", {bus.underrun, bus.overflow});
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (pwm_o !== 2'b00) begin failures++; $display("FAIL first_edge_pwm: got %b required 00", pwm_o); end
  endtask

  task automatic test_duty();
    signed_mode = 1'b0;
    run_frame("duty", {8'h40, 8'hC0}, 18'd1023, 192, 64);
  endtask

  task automatic test_signed();
    signed_mode = 1'b1;
    run_frame("signed_0_7f", {8'h7F, 8'h00}, 18'd511, 128, 255);
    run_frame("signed_80", {8'h80, 8'h80}, 18'd511, 0, 0);
    signed_mode = 1'b0;
  endtask

  task automatic test_underrun();
    int c0, c1;
    bit seen;
    hold_on_underrun = 1'b1;
    run_frame("urun_load", {8'h20, 8'h20}, 18'd511, 32, 32);
    checks++;
    if (bus.underrun !== 1'b0) begin failures++; $display("FAIL urun_pre: got %b required 0", bus.underrun); end
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (bus.underrun) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin failures++; $display("FAIL urun_set: underrun got 0 required 1 within bound"); end
    repeat (3) @(negedge clk);
    count_highs(c0, c1);
    checks++;
    if (c0 !== 32) begin failures++; $display("FAIL urun_hold: highs got %0d required 32", c0); end
    hold_on_underrun = 1'b0;
    repeat (520) @(negedge clk);
    count_highs(c0, c1);
    checks++;
    if (c1 !== 128) begin failures++; $display("FAIL urun_mid: highs got %0d required 128", c1); end
    enable = 1'b0;
    @(negedge clk);
    pulse_clr();
    checks++;
    if (bus.underrun !== 1'b0) begin failures++; $display("FAIL urun_clr: got %b required 0", bus.underrun); end
    hold_on_underrun = 1'b1;
  endtask

  task automatic test_overflow();
    enable = 1'b0;
    @(negedge clk);
    pulse_flush();
    pulse_clr();
    for (int i = 0; i < 4; i++) push(16'(i + 1));
    checks++;
    if (bus.fifo_level !== 3'd4 || bus.fifo_full !== 1'b1 || bus.fifo_empty !== 1'b0) begin
      failures++;
      $display("FAIL ovf_fill: level/full/empty got %0d/%b/%b required 4/1/0",
               bus.fifo_level, bus.fifo_full, bus.fifo_empty);
    end
    push(16'h0055);
    checks++;
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b required 1", bus.overflow); end
    checks++;
    if (bus.fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_level: got %0d required 4", bus.fifo_level); end
    pulse_clr();
    checks++;
    if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr: got %b required 0", bus.overflow); end
    // Push on a tick cycle while full: the pop makes room
    rate_div = '0;
    enable = 1'b1;
    bus.frame_i = 16'h0066;
    bus.we = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    bus.we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.fifo_level !== 3'd4 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_tick_push: level/overflow got %0d/%b required 4/0", bus.fifo_level, bus.overflow);
    end
  endtask

  task automatic test_rate();
    logic [2:0] exp_chg [5] = '{3'd3, 3'd3, 3'd2, 3'd2, 3'd1};
    logic [2:0] exp_lv;
    enable = 1'b0;
    @(negedge clk);
    pulse_flush();
    for (int i = 0; i < 4; i++) push(16'h8080);
    rate_div = 18'd3;
    enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_lv = 3'(4 - k / 4);
      checks++;
      if (bus.fifo_level !== exp_lv) begin
        failures++;
        $display("FAIL rate3_k%0d: level got %0d required %0d", k, bus.fifo_level, exp_lv);
      end
    end
    // Lower the divider once cnt has passed the new value
    enable = 1'b0;
    @(negedge clk);
    pulse_flush();
    for (int i = 0; i < 4; i++) push(16'h8080);
    rate_div = 18'd7;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    rate_div = 18'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.fifo_level !== exp_chg[k]) begin
        failures++;
        $display("FAIL rate_chg_k%0d: level got %0d required %0d", k + 4, bus.fifo_level, exp_chg[k]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_flush_tick();
    int c0, c1;
    bit seen;
    enable = 1'b0;
    @(negedge clk);
    pulse_flush();
    hold_on_underrun = 1'b1;
    signed_mode = 1'b0;
    push({8'h10, 8'h10});
    push({8'hF0, 8'hF0});
    rate_div = 18'd3;
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.fifo_level == 3'd1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin failures++; $display("FAIL flush_first_pop: level never reached 1"); end
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.fifo_level !== 3'd0 || bus.fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL flush_tick_level: level/empty got %0d/%b required 0/1", bus.fifo_level, bus.fifo_empty);
    end
    repeat (3) @(negedge clk);
    count_highs(c0, c1);
    checks++;
    if (c0 !== 16) begin failures++; $display("FAIL flush_tick_sample: highs got %0d required 16", c0); end
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pulse_flush();
    push({8'hFF, 8'hFF});
    push({8'hFF, 8'hFF});
    rate_div = 18'd7;
    enable = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (bus.fifo_level !== 3'd1) begin failures++; $display("FAIL arst_pre_level: got %0d required 1", bus.fifo_level); end
    resetn = 1'b0;
    #1;
    checks++;
    if (pwm_o !== 2'b00) begin failures++; $display("FAIL arst_pwm: got %b required 00", pwm_o); end
    checks++;
    if (bus.fifo_level !== 3'd0 || bus.fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL arst_level: level/empty got %0d/%b required 0/1", bus.fifo_level, bus.fifo_empty);
    end
    @(negedge clk);
    enable = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.we        = 1'b0;
    bus.frame_i   = '0;
    bus.flush     = 1'b0;
    bus.clr_flags = 1'b0;
    test_reset();
    test_duty();
    test_signed();
    test_underrun();
    test_overflow();
    test_rate();
    test_flush_tick();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
